// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter: shares one MIO port between instruction fetch and data access.
// Optional MIO_TIMEOUT_EN: aborts a granted access after TIMEOUT cycles without bus_ready.
module mio_bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        bus_err,
  output logic        stall_if,
  output logic        stall_mem
);
  typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_DM} state_t;
  state_t      state;
  logic        last_dm;
  logic        expire;
  logic        done;
  logic [31:0] done_data;
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("mio_bus_arbiter: TIMEOUT must be 1..65535");
  end
`ifdef MIO_TIMEOUT_EN
  logic [15:0] cnt;
  assign expire = !bus_ready && (cnt + 16'd1 == 16'(TIMEOUT));
`else
  assign expire  = 1'b0;
  assign bus_err = 1'b0;
`endif
  assign done      = bus_ready || expire;
  assign done_data = bus_ready ? bus_rdata : 32'hDEADBEEF;
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = dm_req & ~dm_ack;
  // arbitration, bus sequencing and completion, all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_dm   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= 4'h0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
`ifdef MIO_TIMEOUT_EN
      cnt       <= '0;
      bus_err   <= 1'b0;
`endif
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
`ifdef MIO_TIMEOUT_EN
      bus_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (dm_req && (!if_req || !last_dm)) begin
            state     <= GRANT_DM;
            bus_req   <= 1'b1;
            bus_we    <= dm_we;
            bus_addr  <= dm_addr;
            bus_wdata <= dm_wdata;
            bus_be    <= dm_we ? dm_be : 4'hF;
            last_dm   <= 1'b1;
          end else if (if_req) begin
            state     <= GRANT_IF;
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
            bus_be    <= 4'hF;
            last_dm   <= 1'b0;
          end
`ifdef MIO_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        default: begin
          if (done) begin
            state   <= IDLE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            if (state == GRANT_IF) begin
              if_rdata <= done_data;
              if_ack   <= 1'b1;
            end else begin
              dm_rdata <= done_data;
              dm_ack   <= 1'b1;
            end
`ifdef MIO_TIMEOUT_EN
            bus_err <= expire;
`endif
          end
`ifdef MIO_TIMEOUT_EN
          cnt <= cnt + 16'd1;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mio_bus_arbiter.sv
// tb_mio_bus_arbiter: directed table, corner sequences and randomized model check.
module tb_mio_bus_arbiter;
`ifdef MIO_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_req = 0, dm_req = 0, dm_we = 0, bus_ready = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, bus_rdata = 0;
  logic [3:0]  dm_be = 0;
  logic [31:0] if_rdata, dm_rdata, bus_addr, bus_wdata;
  logic        if_ack, dm_ack, bus_req, bus_we, bus_err, stall_if, stall_mem;
  logic [3:0]  bus_be;
  int checks = 0, failures = 0;

  mio_bus_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_err(bus_err),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic        e_ifa, e_dma;
    logic [31:0] e_rd;
  } vec_t;

  function automatic vec_t mkv(logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
                               logic [31:0] dd, logic [3:0] db, logic rdy, logic [31:0] rd,
                               logic er, logic ew, logic [31:0] ea, logic [31:0] ed,
                               logic [3:0] eb, logic ei, logic edm, logic [31:0] erd);
    vec_t r;
    r = '{ir, ia, dr, dw, da, dd, db, rdy, rd, er, ew, ea, ed, eb, ei, edm, erd};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // behavioural reference: who owns the bus, how long it has waited, what it latched
  int          m_owner;
  int          m_wait;
  bit          m_last_dm;
  logic        m_breq, m_bwe, m_if_ack, m_dm_ack, m_err;
  logic [31:0] m_baddr, m_bwd, m_if_rd, m_dm_rd;
  logic [3:0]  m_bbe;

  task automatic model_reset;
    m_owner = 0; m_wait = 0; m_last_dm = 0;
    m_breq = 0; m_bwe = 0; m_if_ack = 0; m_dm_ack = 0; m_err = 0;
    m_baddr = 0; m_bwd = 0; m_if_rd = 0; m_dm_rd = 0; m_bbe = 0;
  endtask

  task automatic model_finish(input logic [31:0] d, input logic e);
    if (m_owner == 1) begin m_if_rd = d; m_if_ack = 1; end
    else begin m_dm_rd = d; m_dm_ack = 1; end
    m_err = e; m_breq = 0; m_bwe = 0; m_owner = 0;
  endtask

  task automatic model_step;
    m_if_ack = 0; m_dm_ack = 0; m_err = 0;
    if (m_owner == 0) begin
      if (dm_req && (!if_req || !m_last_dm)) begin
        m_owner = 2; m_wait = 0; m_last_dm = 1;
        m_breq = 1; m_bwe = dm_we; m_baddr = dm_addr; m_bwd = dm_wdata;
        m_bbe = dm_we ? dm_be : 4'hF;
      end else if (if_req) begin
        m_owner = 1; m_wait = 0; m_last_dm = 0;
        m_breq = 1; m_bwe = 0; m_baddr = if_addr; m_bwd = 0; m_bbe = 4'hF;
      end
    end else if (bus_ready) begin
      model_finish(bus_rdata, 0);
    end else begin
      m_wait++;
      if (TO != 0 && m_wait == TO) model_finish(32'hDEADBEEF, 1);
    end
  endtask

  vec_t tbl[17];

  initial begin
    tbl[0]  = mkv(0, 0, 1, 1, 32'h1000_0004, 32'hA5A5_1234, 4'h3, 0, 0,            1, 1, 32'h1000_0004, 32'hA5A5_1234, 4'h3, 0, 0, 0);
    tbl[1]  = mkv(0, 0, 1, 1, 32'h1000_0004, 32'hA5A5_1234, 4'h3, 0, 0,            1, 1, 32'h1000_0004, 32'hA5A5_1234, 4'h3, 0, 0, 0);
    tbl[2]  = mkv(0, 0, 1, 1, 32'h1000_0004, 32'hA5A5_1234, 4'h3, 0, 0,            1, 1, 32'h1000_0004, 32'hA5A5_1234, 4'h3, 0, 0, 0);
    tbl[3]  = mkv(0, 0, 1, 1, 32'h1000_0004, 32'hA5A5_1234, 4'h3, 1, 32'h1111_2222, 0, 0, 32'h1000_0004, 32'hA5A5_1234, 4'h3, 0, 1, 32'h1111_2222);
    tbl[4]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,                                        0, 0, 32'h1000_0004, 32'hA5A5_1234, 4'h3, 0, 0, 0);
    tbl[5]  = mkv(1, 32'h40, 0, 0, 0, 0, 0, 0, 0,                                   1, 0, 32'h40, 0, 4'hF, 0, 0, 0);
    tbl[6]  = mkv(1, 32'h40, 0, 0, 0, 0, 0, 1, 32'h2008_0005,                       0, 0, 32'h40, 0, 4'hF, 1, 0, 32'h2008_0005);
    tbl[7]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,                                        0, 0, 32'h40, 0, 4'hF, 0, 0, 0);
    tbl[8]  = mkv(1, 32'h100, 1, 0, 32'h2000, 32'h55, 4'h1, 0, 0,                   1, 0, 32'h2000, 32'h55, 4'hF, 0, 0, 0);
    tbl[9]  = mkv(1, 32'h100, 1, 0, 32'h2000, 32'h55, 4'h1, 1, 32'hAAAA_0001,       0, 0, 32'h2000, 32'h55, 4'hF, 0, 1, 32'hAAAA_0001);
    tbl[10] = mkv(1, 32'h100, 1, 0, 32'h2000, 32'h55, 4'h1, 0, 0,                   1, 0, 32'h100, 0, 4'hF, 0, 0, 0);
    tbl[11] = mkv(1, 32'h100, 1, 0, 32'h2000, 32'h55, 4'h1, 1, 32'hBBBB_0002,       0, 0, 32'h100, 0, 4'hF, 1, 0, 32'hBBBB_0002);
    tbl[12] = mkv(1, 32'h100, 1, 0, 32'h2000, 32'h55, 4'h1, 0, 0,                   1, 0, 32'h2000, 32'h55, 4'hF, 0, 0, 0);
    tbl[13] = mkv(1, 32'h100, 1, 0, 32'h2000, 32'h55, 4'h1, 1, 32'hCCCC_0003,       0, 0, 32'h2000, 32'h55, 4'hF, 0, 1, 32'hCCCC_0003);
    tbl[14] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,                                        0, 0, 32'h2000, 32'h55, 4'hF, 0, 0, 0);
    tbl[15] = mkv(0, 0, 0, 0, 0, 0, 0, 1, 32'hDDDD_0004,                            0, 0, 32'h2000, 32'h55, 4'hF, 0, 0, 0);
    tbl[16] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,                                        0, 0, 32'h2000, 32'h55, 4'hF, 0, 0, 0);

    // reset state
    tick;
    tick;
    chk("rst bus_req", bus_req, 0);
    chk("rst bus_we", bus_we, 0);
    chk("rst bus_addr", bus_addr, 0);
    chk("rst bus_wdata", bus_wdata, 0);
    chk("rst bus_be", bus_be, 0);
    chk("rst if_ack", if_ack, 0);
    chk("rst dm_ack", dm_ack, 0);
    chk("rst if_rdata", if_rdata, 0);
    chk("rst dm_rdata", dm_rdata, 0);
    chk("rst bus_err", bus_err, 0);
    @(negedge clk) rst_n = 1;
    #1;

    // directed table: store, single fetch, contended requests, ready in idle
    for (int i = 0; i < 17; i++) begin
      if_req = tbl[i].if_req; if_addr = tbl[i].if_addr;
      dm_req = tbl[i].dm_req; dm_we = tbl[i].dm_we; dm_addr = tbl[i].dm_addr;
      dm_wdata = tbl[i].dm_wdata; dm_be = tbl[i].dm_be;
      bus_ready = tbl[i].rdy; bus_rdata = tbl[i].rdata;
      tick;
      chk($sformatf("row%0d bus_req", i), bus_req, tbl[i].e_req);
      chk($sformatf("row%0d bus_we", i), bus_we, tbl[i].e_we);
      chk($sformatf("row%0d bus_addr", i), bus_addr, tbl[i].e_addr);
      chk($sformatf("row%0d bus_wdata", i), bus_wdata, tbl[i].e_wdata);
      chk($sformatf("row%0d bus_be", i), bus_be, tbl[i].e_be);
      chk($sformatf("row%0d if_ack", i), if_ack, tbl[i].e_ifa);
      chk($sformatf("row%0d dm_ack", i), dm_ack, tbl[i].e_dma);
      chk($sformatf("row%0d bus_err", i), bus_err, 0);
      chk($sformatf("row%0d stall_if", i), stall_if, tbl[i].if_req & ~tbl[i].e_ifa);
      chk($sformatf("row%0d stall_mem", i), stall_mem, tbl[i].dm_req & ~tbl[i].e_dma);
      if (tbl[i].e_ifa) chk($sformatf("row%0d if_rdata", i), if_rdata, tbl[i].e_rd);
      if (tbl[i].e_dma) chk($sformatf("row%0d dm_rdata", i), dm_rdata, tbl[i].e_rd);
    end

    // reset in the middle of a data access
    dm_req = 1; dm_we = 0; dm_addr = 32'h3000; bus_ready = 0;
    tick;
    chk("mid bus_req granted", bus_req, 1);
    rst_n = 0;
    #1;
    chk("mid bus_req async drop", bus_req, 0);
    tick;
    chk("mid dm_ack none", dm_ack, 0);
    chk("mid bus_req held low", bus_req, 0);
    dm_req = 0; if_req = 1; if_addr = 32'h0000_0080;
    @(negedge clk) rst_n = 1;
    tick;
    chk("post-rst bus_req", bus_req, 1);
    chk("post-rst bus_addr", bus_addr, 32'h80);
    chk("post-rst bus_we", bus_we, 0);
    chk("post-rst dm_ack", dm_ack, 0);
    bus_ready = 1; bus_rdata = 32'h0BAD_F00D;
    tick;
    chk("post-rst if_ack", if_ack, 1);
    chk("post-rst if_rdata", if_rdata, 32'h0BAD_F00D);
    if_req = 0; bus_ready = 0;
    tick;
    chk("post-rst ack one cycle", if_ack, 0);

`ifdef MIO_TIMEOUT_EN
    // timeout: ready never comes
    if_req = 1; if_addr = 32'h44;
    tick;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("to wait if_ack", if_ack, 0);
      chk("to wait bus_err", bus_err, 0);
    end
    tick;
    chk("to if_ack", if_ack, 1);
    chk("to if_rdata", if_rdata, 32'hDEADBEEF);
    chk("to bus_err", bus_err, 1);
    chk("to bus_req", bus_req, 0);
    if_req = 0;
    tick;
    chk("to bus_err pulse", bus_err, 0);
    chk("to if_ack pulse", if_ack, 0);
    // ready on the timeout edge wins
    if_req = 1;
    tick;
    for (int k = 0; k < 3; k++) tick;
    chk("tie no early ack", if_ack, 0);
    bus_ready = 1; bus_rdata = 32'h1234_5678;
    tick;
    chk("tie if_ack", if_ack, 1);
    chk("tie if_rdata", if_rdata, 32'h1234_5678);
    chk("tie bus_err", bus_err, 0);
    if_req = 0; bus_ready = 0;
    tick;
`else
    // without the timeout, a granted access waits indefinitely
    if_req = 1; if_addr = 32'h44;
    tick;
    for (int k = 0; k < 20; k++) begin
      tick;
      chk("wait bus_req", bus_req, 1);
      chk("wait if_ack", if_ack, 0);
    end
    bus_ready = 1; bus_rdata = 32'h1234_5678;
    tick;
    chk("wait if_ack", if_ack, 1);
    chk("wait if_rdata", if_rdata, 32'h1234_5678);
    if_req = 0; bus_ready = 0;
    tick;
`endif

    // randomized traffic against the reference model
    rst_n = 0;
    tick;
    @(negedge clk) rst_n = 1;
    #1;
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      if (!if_req || m_if_ack) begin
        if_req = ($urandom_range(0, 2) != 0); if_addr = $urandom;
      end else if ($urandom_range(0, 15) == 0) if_req = 0;
      if (!dm_req || m_dm_ack) begin
        dm_req = ($urandom_range(0, 2) != 0); dm_we = 1'($urandom_range(0, 1));
        dm_addr = $urandom; dm_wdata = $urandom; dm_be = 4'($urandom_range(0, 15));
      end else if ($urandom_range(0, 15) == 0) dm_req = 0;
      bus_ready = ($urandom_range(0, 9) < 4);
      bus_rdata = $urandom;
      model_step();
      tick;
      chk("rnd bus_req", bus_req, m_breq);
      chk("rnd bus_we", bus_we, m_bwe);
      chk("rnd bus_addr", bus_addr, m_baddr);
      chk("rnd bus_wdata", bus_wdata, m_bwd);
      chk("rnd bus_be", bus_be, m_bbe);
      chk("rnd if_ack", if_ack, m_if_ack);
      chk("rnd dm_ack", dm_ack, m_dm_ack);
      chk("rnd if_rdata", if_rdata, m_if_rd);
      chk("rnd dm_rdata", dm_rdata, m_dm_rd);
      chk("rnd bus_err", bus_err, m_err);
      chk("rnd stall_if", stall_if, if_req & ~m_if_ack);
      chk("rnd stall_mem", stall_mem, dm_req & ~m_dm_ack);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mio_bus_arbiter.md
Name: mio_bus_arbiter

Overview:
- Shares the CPU's single memory/IO port between two requesters:
  - instruction fetch (IF stage)
  - data access (MEM stage: loads and stores)
- Sequences each access through a request/ready handshake with the external MIO bus.
- Returns read data and a one-cycle acknowledge to the winner.
- Drives stall signals that the pipeline hazard logic uses to freeze PC, IF_ID and downstream registers while an access is outstanding.

Parameters:
- TIMEOUT, 255, cycles a granted access may wait for bus_ready before abort. Used only when the optional feature is compiled in; range 1..65535.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched instruction, valid while if_ack=1
- if_ack  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request, held until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  32  data byte address
- dm_wdata  in  32  store data
- dm_be  in  4  store byte enables
- dm_rdata  out  32  load data, valid while dm_ack=1
- dm_ack  out  1  one-cycle completion pulse for data
- bus_req  out  1  to CPU_MIO: access in progress
- bus_we  out  1  to mem_w
- bus_addr  out  32  to Addr_out
- bus_wdata  out  32  to Data_out
- bus_be  out  4  byte enables to memory
- bus_rdata  in  32  from Data_in
- bus_ready  in  1  from MIO_ready: access complete this cycle
- bus_err  out  1  one-cycle pulse on timeout abort (constant 0 without the optional feature)
- stall_if  out  1  if_req & ~if_ack (combinational)
- stall_mem  out  1  dm_req & ~dm_ack (combinational)

Behaviour:
- Reset (async, rst_n=0), effective immediately:
  - FSM goes to IDLE.
  - bus_req, bus_we, bus_err, if_ack, dm_ack = 0.
  - bus_addr, bus_wdata, if_rdata, dm_rdata = 0; bus_be = 4'h0; last_dm = 0.
  - Reset during an active access aborts it: no ack is produced and bus_req drops without waiting for bus_ready.
- FSM states: IDLE, GRANT_IF, GRANT_DM.
- IDLE, arbitration at the clock edge:
  - If dm_req and (!if_req or !last_dm): go to GRANT_DM.
  - Else if if_req: go to GRANT_IF.
  - Else: stay in IDLE.
  - Data has priority, but DM is never granted twice in a row while IF is waiting.
- On entering a grant, all bus_* outputs are registered and held stable for the whole access:
  - GRANT_DM: bus_req=1, bus_we=dm_we, bus_addr=dm_addr, bus_wdata=dm_wdata, bus_be = dm_we ? dm_be : 4'hF. last_dm is set to 1.
  - GRANT_IF: bus_req=1, bus_we=0, bus_addr=if_addr, bus_wdata=0, bus_be=4'hF. last_dm is cleared to 0.
- In a grant state, each edge with bus_ready=1:
  - Capture bus_rdata into the winner's rdata register.
  - Pulse the winner's ack for exactly one cycle.
  - Clear bus_req and bus_we; return to IDLE.
- In a grant state, bus_ready=0: hold all outputs, stay.
- Latency: request at edge N, bus_req high after edge N, ready sampled at edge N+1 at the earliest, ack high after edge N+1. Minimum 2 cycles request-to-ack; one access per 2 cycles maximum throughput.
- The IDLE cycle between accesses is mandatory. No back-to-back grant is made on the ack edge.
- A requester that drops req before being granted is simply not served.
- A requester that drops req after being granted: the access still completes and the ack still pulses; the requester ignores it.
- bus_ready while in IDLE is ignored.
- Stores: dm_rdata is still updated with bus_rdata on completion, and is don't-care for the requester.
- Addresses pass through unmodified. The arbiter performs no alignment check; byte-enable generation upstream owns alignment.

Optional Feature:
- Macro: MIO_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter clears on grant entry and increments each grant cycle with bus_ready=0.
  - When the counter reaches TIMEOUT, the access aborts at that edge: the winner's ack pulses with rdata = 32'hDEADBEEF, bus_err pulses for one cycle, bus_req drops, FSM returns to IDLE.
  - bus_ready on the same edge as the timeout wins: normal completion, no bus_err.
- Undefined:
  - No counter; the arbiter waits indefinitely.
  - bus_err is tied to 0.

Test Plan:
- Single IF read: if_req=1, if_addr=0x0000_0040, bus_ready=1 one cycle after bus_req -> bus_addr=0x40, bus_we=0, bus_be=F; if_ack pulses 2 cycles after request with if_rdata=bus_rdata (e.g. 0x2008_0005).
- Store: dm_req=1, dm_we=1, dm_addr=0x1000_0004, dm_wdata=0xA5A5_1234, dm_be=4'b0011, bus_ready delayed 3 cycles -> bus outputs stable for 4 cycles; stall_mem=1 until dm_ack; exactly one dm_ack pulse.
- Simultaneous requests held for 3 transactions -> grant order DM, IF, DM; each grant separated by one IDLE cycle; stall_if stays 1 through the first DM access.
- Reset mid-access: assert rst_n=0 while in GRANT_DM with bus_ready=0 -> bus_req=0 in the same cycle, no dm_ack; after release with if_req=1 -> IF granted normally.
- Timeout (MIO_TIMEOUT_EN, TIMEOUT=4): bus_ready never asserted -> after 4 wait cycles, if_ack=1 with if_rdata=0xDEADBEEF and bus_err=1 for one cycle; FSM back to IDLE.
- Timeout tie (MIO_TIMEOUT_EN): bus_ready=1 on exactly the TIMEOUT edge -> normal data returned, bus_err=0.
